// File: rtl/alu_pkg.sv
// Shared ALU/condition types: condition codes, flag and flag-write indices.
// Imported by cond_check and cond_logic.
package alu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: cond_i vs {N,Z,C,V} -> cond_ex_o.
// Ports: cond_i (condition code), flags_i (NZCV), cond_ex_o (passed).
module cond_check
  import alu_pkg::*;
(
  input  cond_e       cond_i,
  input  logic [3:0]  flags_i,
  output logic        cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b0;
    unique case (cond_i)
      EQ: cond_ex_o = z;
      NE: cond_ex_o = ~z;
      CS: cond_ex_o = c;
      CC: cond_ex_o = ~c;
      MI: cond_ex_o = n;
      PL: cond_ex_o = ~n;
      VS: cond_ex_o = v;
      VC: cond_ex_o = ~v;
      HI: cond_ex_o = c & ~z;
      LS: cond_ex_o = ~c | z;
      GE: cond_ex_o = ~(n ^ v);
      LT: cond_ex_o = n ^ v;
      GT: cond_ex_o = ~z & ~(n ^ v);
      LE: cond_ex_o = z | (n ^ v);
      AL: cond_ex_o = 1'b1;
      NV: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// NZCV flag register plus condition-gated PC/regfile/memory write strobes.
// Ports: clk, reset_n, en, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
//   no_write in; pc_src, reg_write, mem_write, cond_ex, flags out.
module cond_logic
  import alu_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [3:0]  cond,
  input  logic [3:0]  alu_flags,
  input  logic [1:0]  flag_w,
  input  logic        pcs,
  input  logic        reg_w,
  input  logic        mem_w,
  input  logic        no_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_write,
  output logic        cond_ex,
  output logic [3:0]  flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       fire;

  assign flags = {nz_q, cv_q};

  // Evaluated against the stored flags only, so an S-suffixed
  // conditional instruction is gated by the pre-instruction flags.
  cond_check u_cond_check (
    .cond_i    (cond_e'(cond)),
    .flags_i   (flags),
    .cond_ex_o (cond_ex)
  );

  assign fire      = en & cond_ex;
  assign pc_src    = fire & pcs;
  assign reg_write = fire & reg_w & ~no_write;
  assign mem_write = fire & mem_w;

  // NZ and CV update independently: logical S-ops keep C and V.
  assign nz_d = (fire & flag_w[FW_NZ]) ? alu_flags[3:2] : nz_q;
  assign cv_d = (fire & flag_w[FW_CV]) ? alu_flags[1:0] : cv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nz_q <= RESET_FLAGS[3:2];
      cv_q <= RESET_FLAGS[1:0];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic with an expected-value queue scoreboard.
// Compares {pc_src,reg_write,mem_write,cond_ex,flags} at each step.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs, reg_w, mem_w, no_write;
  logic       pc_src, reg_write, mem_write, cond_ex;
  logic [3:0] flags;

  logic [3:0] mf;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  cond_logic #(.RESET_FLAGS(4'b0000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .cond_ex   (cond_ex),
    .flags     (flags)
  );

  function automatic bit mcond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, b;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      default: b = !z && (n == v);
    endcase
    return b ^ c[0];
  endfunction

  function automatic logic [7:0] mexp();
    bit p;
    p = mcond(cond, mf);
    return {en && p && pcs,
            en && p && reg_w && !no_write,
            en && p && mem_w,
            p, mf};
  endfunction

  task automatic check(input string tag);
    logic [7:0] e, o;
    string t;
    exp_q.push_back(mexp());
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {pc_src, reg_write, mem_write, cond_ex, flags};
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask

  task automatic tick();
    bit p;
    p = mcond(cond, mf);
    @(posedge clk);
    if (!reset_n) mf = 4'b0000;
    else begin
      if (en && p && flag_w[1]) mf[3:2] = alu_flags[3:2];
      if (en && p && flag_w[0]) mf[1:0] = alu_flags[1:0];
    end
    #1;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; cond = 4'hE; alu_flags = 4'h0;
    flag_w = 2'b00; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    no_write = 1'b0; mf = 4'b0000;
    #3;
    check("rst_init");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    en = 1'b1; cond = 4'hE; flag_w = 2'b11; alu_flags = 4'hF;
    tick();
    check("load_1111");

    // asynchronous reset mid-cycle with an update pending
    #2;
    reset_n = 1'b0;
    mf = 4'b0000;
    check("rst_async");
    cond = 4'h0;
    check("rst_eq");
    cond = 4'h1;
    check("rst_ne");
    cond = 4'hE;
    tick();
    check("rst_discard");
    reset_n = 1'b1;
    en = 1'b0;
    check("rst_release");

    en = 1'b1; cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b1010;
    tick();
    check("part_full");
    flag_w = 2'b10; alu_flags = 4'b0101;
    tick();
    check("part_nz_only");

    for (int f = 0; f < 16; f++) begin
      en = 1'b1; cond = 4'hE; flag_w = 2'b11;
      pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
      alu_flags = 4'(f);
      tick();
      flag_w = 2'b00; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        check($sformatf("sweep_f%0h_c%0h", f, c));
      end
    end

    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b0100;
    tick();
    cond = 4'h1; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    alu_flags = 4'b1011;
    check("gate_ne_fail");
    tick();
    check("gate_hold");

    cond = 4'hE; pcs = 1'b0; mem_w = 1'b0; reg_w = 1'b1;
    no_write = 1'b1; flag_w = 2'b11; alu_flags = 4'b0110;
    check("cmp_nowrite");
    tick();
    check("cmp_flags");
    no_write = 1'b0;

    en = 1'b0; flag_w = 2'b11; alu_flags = 4'hF;
    pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_pre%0d", i));
      tick();
      check($sformatf("stall_post%0d", i));
    end
    en = 1'b1;
    tick();
    check("stall_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
